// File: rtl/mem_axi4_arbiter_pkg.sv
// Shared types and helpers for the two-requester AXI4 arbiter.
package mem_axi4_arbiter_pkg;

  localparam int REQ_IDX_BITS = 1;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2
  } w_state_e;

  // Two contenders go to the pointer; a lone requester always wins.
  function automatic logic [REQ_IDX_BITS-1:0] rr_pick(input logic [1:0] valid,
                                                      input logic [REQ_IDX_BITS-1:0] ptr);
    if (valid[0] && valid[1]) return ptr;
    return valid[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; lock forces the grant to a held index.
module rr_arb2
  import mem_axi4_arbiter_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              valid,
  input  logic                    lock,
  input  logic [REQ_IDX_BITS-1:0] lock_idx,
  input  logic                    accept,
  output logic [REQ_IDX_BITS-1:0] grant
);

  logic [REQ_IDX_BITS-1:0] ptr;

  assign grant = lock ? lock_idx : rr_pick(valid, ptr);

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ~grant;
    end
  end

endmodule

// File: rtl/mem_axi4_arbiter.sv
// Arbitrates two AXI4 requesters onto one slave port; the requester index rides in the id MSB.
module mem_axi4_arbiter
  import mem_axi4_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = 34,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 4
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    m0_ar_valid,
  output logic                    m0_ar_ready,
  input  logic [ADDR_BITS-1:0]    m0_ar_bits_addr,
  input  logic [ID_BITS-1:0]      m0_ar_bits_id,
  input  logic [2:0]              m0_ar_bits_size,
  input  logic [7:0]              m0_ar_bits_len,
  input  logic                    m0_aw_valid,
  output logic                    m0_aw_ready,
  input  logic [ADDR_BITS-1:0]    m0_aw_bits_addr,
  input  logic [ID_BITS-1:0]      m0_aw_bits_id,
  input  logic [2:0]              m0_aw_bits_size,
  input  logic [7:0]              m0_aw_bits_len,
  input  logic                    m0_w_valid,
  output logic                    m0_w_ready,
  input  logic [DATA_BITS/8-1:0]  m0_w_bits_strb,
  input  logic [DATA_BITS-1:0]    m0_w_bits_data,
  input  logic                    m0_w_bits_last,
  output logic                    m0_r_valid,
  input  logic                    m0_r_ready,
  output logic [1:0]              m0_r_bits_resp,
  output logic [ID_BITS-1:0]      m0_r_bits_id,
  output logic [DATA_BITS-1:0]    m0_r_bits_data,
  output logic                    m0_r_bits_last,
  output logic                    m0_b_valid,
  input  logic                    m0_b_ready,
  output logic [1:0]              m0_b_bits_resp,
  output logic [ID_BITS-1:0]      m0_b_bits_id,

  input  logic                    m1_ar_valid,
  output logic                    m1_ar_ready,
  input  logic [ADDR_BITS-1:0]    m1_ar_bits_addr,
  input  logic [ID_BITS-1:0]      m1_ar_bits_id,
  input  logic [2:0]              m1_ar_bits_size,
  input  logic [7:0]              m1_ar_bits_len,
  input  logic                    m1_aw_valid,
  output logic                    m1_aw_ready,
  input  logic [ADDR_BITS-1:0]    m1_aw_bits_addr,
  input  logic [ID_BITS-1:0]      m1_aw_bits_id,
  input  logic [2:0]              m1_aw_bits_size,
  input  logic [7:0]              m1_aw_bits_len,
  input  logic                    m1_w_valid,
  output logic                    m1_w_ready,
  input  logic [DATA_BITS/8-1:0]  m1_w_bits_strb,
  input  logic [DATA_BITS-1:0]    m1_w_bits_data,
  input  logic                    m1_w_bits_last,
  output logic                    m1_r_valid,
  input  logic                    m1_r_ready,
  output logic [1:0]              m1_r_bits_resp,
  output logic [ID_BITS-1:0]      m1_r_bits_id,
  output logic [DATA_BITS-1:0]    m1_r_bits_data,
  output logic                    m1_r_bits_last,
  output logic                    m1_b_valid,
  input  logic                    m1_b_ready,
  output logic [1:0]              m1_b_bits_resp,
  output logic [ID_BITS-1:0]      m1_b_bits_id,

  output logic                    s_ar_valid,
  input  logic                    s_ar_ready,
  output logic [ADDR_BITS-1:0]    s_ar_bits_addr,
  output logic [ID_BITS:0]        s_ar_bits_id,
  output logic [2:0]              s_ar_bits_size,
  output logic [7:0]              s_ar_bits_len,
  output logic                    s_aw_valid,
  input  logic                    s_aw_ready,
  output logic [ADDR_BITS-1:0]    s_aw_bits_addr,
  output logic [ID_BITS:0]        s_aw_bits_id,
  output logic [2:0]              s_aw_bits_size,
  output logic [7:0]              s_aw_bits_len,
  output logic                    s_w_valid,
  input  logic                    s_w_ready,
  output logic [DATA_BITS/8-1:0]  s_w_bits_strb,
  output logic [DATA_BITS-1:0]    s_w_bits_data,
  output logic                    s_w_bits_last,
  input  logic                    s_r_valid,
  output logic                    s_r_ready,
  input  logic [1:0]              s_r_bits_resp,
  input  logic [ID_BITS:0]        s_r_bits_id,
  input  logic [DATA_BITS-1:0]    s_r_bits_data,
  input  logic                    s_r_bits_last,
  input  logic                    s_b_valid,
  output logic                    s_b_ready,
  input  logic [1:0]              s_b_bits_resp,
  input  logic [ID_BITS:0]        s_b_bits_id
);

  // ---------------- read address ----------------
  logic                    ar_lock;
  logic [REQ_IDX_BITS-1:0] ar_held;
  logic [REQ_IDX_BITS-1:0] ar_grant;

  rr_arb2 u_ar_arb (
    .clock    (clock),
    .reset    (reset),
    .valid    ({m1_ar_valid, m0_ar_valid}),
    .lock     (ar_lock),
    .lock_idx (ar_held),
    .accept   (s_ar_valid && s_ar_ready),
    .grant    (ar_grant)
  );

  // A stalled grant stays put so the slave sees stable ar bits until it accepts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ar_lock <= 1'b0;
      ar_held <= '0;
    end else begin
      ar_lock <= s_ar_valid && !s_ar_ready;
      ar_held <= ar_grant;
    end
  end

  assign s_ar_valid     = reset && (ar_grant[0] ? m1_ar_valid : m0_ar_valid);
  assign s_ar_bits_addr = ar_grant[0] ? m1_ar_bits_addr : m0_ar_bits_addr;
  assign s_ar_bits_id   = {ar_grant, (ar_grant[0] ? m1_ar_bits_id : m0_ar_bits_id)};
  assign s_ar_bits_size = ar_grant[0] ? m1_ar_bits_size : m0_ar_bits_size;
  assign s_ar_bits_len  = ar_grant[0] ? m1_ar_bits_len : m0_ar_bits_len;
  assign m0_ar_ready    = reset && s_ar_ready && !ar_grant[0];
  assign m1_ar_ready    = reset && s_ar_ready && ar_grant[0];

  // ---------------- write address / data ----------------
  w_state_e                w_state, w_state_d;
  logic [REQ_IDX_BITS-1:0] w_winner, w_winner_d;
  logic [REQ_IDX_BITS-1:0] aw_pick;

  rr_arb2 u_aw_arb (
    .clock    (clock),
    .reset    (reset),
    .valid    ({m1_aw_valid, m0_aw_valid}),
    .lock     (w_state != W_IDLE),
    .lock_idx (w_winner),
    .accept   (s_aw_valid && s_aw_ready),
    .grant    (aw_pick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      w_state  <= W_IDLE;
      w_winner <= '0;
    end else begin
      w_state  <= w_state_d;
      w_winner <= w_winner_d;
    end
  end

  assign s_aw_bits_addr = w_winner[0] ? m1_aw_bits_addr : m0_aw_bits_addr;
  assign s_aw_bits_id   = {w_winner, (w_winner[0] ? m1_aw_bits_id : m0_aw_bits_id)};
  assign s_aw_bits_size = w_winner[0] ? m1_aw_bits_size : m0_aw_bits_size;
  assign s_aw_bits_len  = w_winner[0] ? m1_aw_bits_len : m0_aw_bits_len;
  assign s_w_bits_strb  = w_winner[0] ? m1_w_bits_strb : m0_w_bits_strb;
  assign s_w_bits_data  = w_winner[0] ? m1_w_bits_data : m0_w_bits_data;
  assign s_w_bits_last  = w_winner[0] ? m1_w_bits_last : m0_w_bits_last;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_state_d   = w_state;
    w_winner_d  = w_winner;
    s_aw_valid  = 1'b0;
    s_w_valid   = 1'b0;
    m0_aw_ready = 1'b0;
    m1_aw_ready = 1'b0;
    m0_w_ready  = 1'b0;
    m1_w_ready  = 1'b0;
    if (reset) begin
      unique case (w_state)
        W_IDLE: begin
          if (m0_aw_valid || m1_aw_valid) begin
            w_winner_d = aw_pick;
            w_state_d  = W_ADDR;
          end
        end
        W_ADDR: begin
          s_aw_valid  = w_winner[0] ? m1_aw_valid : m0_aw_valid;
          m0_aw_ready = s_aw_ready && !w_winner[0];
          m1_aw_ready = s_aw_ready && w_winner[0];
          if (s_aw_valid && s_aw_ready) w_state_d = W_DATA;
        end
        W_DATA: begin
          s_w_valid  = w_winner[0] ? m1_w_valid : m0_w_valid;
          m0_w_ready = s_w_ready && !w_winner[0];
          m1_w_ready = s_w_ready && w_winner[0];
          if (s_w_valid && s_w_ready && s_w_bits_last) w_state_d = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

  // ---------------- responses: steered purely by the returned id MSB ----------------
  logic r_sel, b_sel;
  assign r_sel = s_r_bits_id[ID_BITS];
  assign b_sel = s_b_bits_id[ID_BITS];

  assign m0_r_valid     = reset && s_r_valid && !r_sel;
  assign m1_r_valid     = reset && s_r_valid && r_sel;
  assign s_r_ready      = reset && (r_sel ? m1_r_ready : m0_r_ready);
  assign m0_r_bits_resp = s_r_bits_resp;
  assign m1_r_bits_resp = s_r_bits_resp;
  assign m0_r_bits_id   = s_r_bits_id[ID_BITS-1:0];
  assign m1_r_bits_id   = s_r_bits_id[ID_BITS-1:0];
  assign m0_r_bits_data = s_r_bits_data;
  assign m1_r_bits_data = s_r_bits_data;
  assign m0_r_bits_last = s_r_bits_last;
  assign m1_r_bits_last = s_r_bits_last;

  assign m0_b_valid     = reset && s_b_valid && !b_sel;
  assign m1_b_valid     = reset && s_b_valid && b_sel;
  assign s_b_ready      = reset && (b_sel ? m1_b_ready : m0_b_ready);
  assign m0_b_bits_resp = s_b_bits_resp;
  assign m1_b_bits_resp = s_b_bits_resp;
  assign m0_b_bits_id   = s_b_bits_id[ID_BITS-1:0];
  assign m1_b_bits_id   = s_b_bits_id[ID_BITS-1:0];

endmodule

// File: tb/tb_mem_axi4_arbiter.sv
// Directed bench for mem_axi4_arbiter: arbitration, lock, bursts, response routing, reset.
module tb_mem_axi4_arbiter;

  localparam int A = 34;
  localparam int D = 64;
  localparam int I = 4;

  logic clock, reset;

  logic m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
  logic [A-1:0] m0_ar_bits_addr, m1_ar_bits_addr;
  logic [I-1:0] m0_ar_bits_id, m1_ar_bits_id;
  logic [2:0] m0_ar_bits_size, m1_ar_bits_size;
  logic [7:0] m0_ar_bits_len, m1_ar_bits_len;
  logic m0_aw_valid, m0_aw_ready, m1_aw_valid, m1_aw_ready;
  logic [A-1:0] m0_aw_bits_addr, m1_aw_bits_addr;
  logic [I-1:0] m0_aw_bits_id, m1_aw_bits_id;
  logic [2:0] m0_aw_bits_size, m1_aw_bits_size;
  logic [7:0] m0_aw_bits_len, m1_aw_bits_len;
  logic m0_w_valid, m0_w_ready, m1_w_valid, m1_w_ready;
  logic [D/8-1:0] m0_w_bits_strb, m1_w_bits_strb;
  logic [D-1:0] m0_w_bits_data, m1_w_bits_data;
  logic m0_w_bits_last, m1_w_bits_last;
  logic m0_r_valid, m0_r_ready, m1_r_valid, m1_r_ready;
  logic [1:0] m0_r_bits_resp, m1_r_bits_resp;
  logic [I-1:0] m0_r_bits_id, m1_r_bits_id;
  logic [D-1:0] m0_r_bits_data, m1_r_bits_data;
  logic m0_r_bits_last, m1_r_bits_last;
  logic m0_b_valid, m0_b_ready, m1_b_valid, m1_b_ready;
  logic [1:0] m0_b_bits_resp, m1_b_bits_resp;
  logic [I-1:0] m0_b_bits_id, m1_b_bits_id;

  logic s_ar_valid, s_ar_ready;
  logic [A-1:0] s_ar_bits_addr;
  logic [I:0] s_ar_bits_id;
  logic [2:0] s_ar_bits_size;
  logic [7:0] s_ar_bits_len;
  logic s_aw_valid, s_aw_ready;
  logic [A-1:0] s_aw_bits_addr;
  logic [I:0] s_aw_bits_id;
  logic [2:0] s_aw_bits_size;
  logic [7:0] s_aw_bits_len;
  logic s_w_valid, s_w_ready;
  logic [D/8-1:0] s_w_bits_strb;
  logic [D-1:0] s_w_bits_data;
  logic s_w_bits_last;
  logic s_r_valid, s_r_ready;
  logic [1:0] s_r_bits_resp;
  logic [I:0] s_r_bits_id;
  logic [D-1:0] s_r_bits_data;
  logic s_r_bits_last;
  logic s_b_valid, s_b_ready;
  logic [1:0] s_b_bits_resp;
  logic [I:0] s_b_bits_id;

  mem_axi4_arbiter #(.ADDR_BITS(A), .DATA_BITS(D), .ID_BITS(I)) dut (
    .clock(clock), .reset(reset),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_bits_addr(m0_ar_bits_addr),
    .m0_ar_bits_id(m0_ar_bits_id), .m0_ar_bits_size(m0_ar_bits_size), .m0_ar_bits_len(m0_ar_bits_len),
    .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready), .m0_aw_bits_addr(m0_aw_bits_addr),
    .m0_aw_bits_id(m0_aw_bits_id), .m0_aw_bits_size(m0_aw_bits_size), .m0_aw_bits_len(m0_aw_bits_len),
    .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready), .m0_w_bits_strb(m0_w_bits_strb),
    .m0_w_bits_data(m0_w_bits_data), .m0_w_bits_last(m0_w_bits_last),
    .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_bits_resp(m0_r_bits_resp),
    .m0_r_bits_id(m0_r_bits_id), .m0_r_bits_data(m0_r_bits_data), .m0_r_bits_last(m0_r_bits_last),
    .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready), .m0_b_bits_resp(m0_b_bits_resp),
    .m0_b_bits_id(m0_b_bits_id),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_bits_addr(m1_ar_bits_addr),
    .m1_ar_bits_id(m1_ar_bits_id), .m1_ar_bits_size(m1_ar_bits_size), .m1_ar_bits_len(m1_ar_bits_len),
    .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_aw_bits_addr(m1_aw_bits_addr),
    .m1_aw_bits_id(m1_aw_bits_id), .m1_aw_bits_size(m1_aw_bits_size), .m1_aw_bits_len(m1_aw_bits_len),
    .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready), .m1_w_bits_strb(m1_w_bits_strb),
    .m1_w_bits_data(m1_w_bits_data), .m1_w_bits_last(m1_w_bits_last),
    .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_bits_resp(m1_r_bits_resp),
    .m1_r_bits_id(m1_r_bits_id), .m1_r_bits_data(m1_r_bits_data), .m1_r_bits_last(m1_r_bits_last),
    .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready), .m1_b_bits_resp(m1_b_bits_resp),
    .m1_b_bits_id(m1_b_bits_id),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_bits_addr(s_ar_bits_addr),
    .s_ar_bits_id(s_ar_bits_id), .s_ar_bits_size(s_ar_bits_size), .s_ar_bits_len(s_ar_bits_len),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_bits_addr(s_aw_bits_addr),
    .s_aw_bits_id(s_aw_bits_id), .s_aw_bits_size(s_aw_bits_size), .s_aw_bits_len(s_aw_bits_len),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_bits_strb(s_w_bits_strb),
    .s_w_bits_data(s_w_bits_data), .s_w_bits_last(s_w_bits_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_bits_resp(s_r_bits_resp),
    .s_r_bits_id(s_r_bits_id), .s_r_bits_data(s_r_bits_data), .s_r_bits_last(s_r_bits_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_bits_resp(s_b_bits_resp),
    .s_b_bits_id(s_b_bits_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    {m0_ar_valid, m1_ar_valid, m0_aw_valid, m1_aw_valid, m0_w_valid, m1_w_valid} = '0;
    {m0_r_ready, m1_r_ready, m0_b_ready, m1_b_ready} = '0;
    {s_ar_ready, s_aw_ready, s_w_ready, s_r_valid, s_b_valid} = '0;
    m0_ar_bits_addr = '0; m1_ar_bits_addr = '0; m0_ar_bits_id = '0; m1_ar_bits_id = '0;
    m0_ar_bits_size = 3'd3; m1_ar_bits_size = 3'd3; m0_ar_bits_len = '0; m1_ar_bits_len = '0;
    m0_aw_bits_addr = '0; m1_aw_bits_addr = '0; m0_aw_bits_id = '0; m1_aw_bits_id = '0;
    m0_aw_bits_size = 3'd3; m1_aw_bits_size = 3'd3; m0_aw_bits_len = 8'd3; m1_aw_bits_len = 8'd3;
    m0_w_bits_strb = 8'hff; m1_w_bits_strb = 8'hff; m0_w_bits_data = '0; m1_w_bits_data = '0;
    m0_w_bits_last = 1'b0; m1_w_bits_last = 1'b0;
    s_r_bits_resp = '0; s_r_bits_id = '0; s_r_bits_data = '0; s_r_bits_last = 1'b0;
    s_b_bits_resp = '0; s_b_bits_id = '0;

    // Reset with every upstream handshake input active: all ready/valid outputs stay low.
    reset = 1'b0;
    m0_ar_valid = 1; s_ar_ready = 1; s_r_valid = 1; s_r_bits_id = 5'b0_0001; m0_r_ready = 1;
    m0_aw_valid = 1; s_aw_ready = 1; m0_w_valid = 1; s_w_ready = 1; s_b_valid = 1; m0_b_ready = 1;
    tick; tick;
    check("rst_s_ar_valid", s_ar_valid, 0);
    check("rst_m0_ar_ready", m0_ar_ready, 0);
    check("rst_m0_r_valid", m0_r_valid, 0);
    check("rst_s_r_ready", s_r_ready, 0);
    check("rst_s_aw_valid", s_aw_valid, 0);
    check("rst_s_w_valid", s_w_valid, 0);
    check("rst_m0_w_ready", m0_w_ready, 0);
    check("rst_m0_b_valid", m0_b_valid, 0);
    {m0_ar_valid, s_ar_ready, s_r_valid, m0_r_ready, m0_aw_valid, s_aw_ready} = '0;
    {m0_w_valid, s_w_ready, s_b_valid, m0_b_ready} = '0;
    reset = 1'b1;
    tick;

    // Simultaneous AR, pointer 0: m0 first, then m1.
    m0_ar_valid = 1; m0_ar_bits_addr = 34'h1_0000_0100; m0_ar_bits_id = 4'h2;
    m1_ar_valid = 1; m1_ar_bits_addr = 34'h2_0000_0200; m1_ar_bits_id = 4'h9;
    s_ar_ready = 1;
    #1;
    check("ar_first_valid", s_ar_valid, 1);
    check("ar_first_id", s_ar_bits_id, 5'h02);
    check("ar_first_addr", s_ar_bits_addr, 34'h1_0000_0100);
    check("ar_first_m0_ready", m0_ar_ready, 1);
    check("ar_first_m1_ready", m1_ar_ready, 0);
    tick;
    m0_ar_bits_addr = 34'h1_0000_0140;
    #1;
    check("ar_second_id", s_ar_bits_id, 5'h19);
    check("ar_second_addr", s_ar_bits_addr, 34'h2_0000_0200);
    check("ar_second_m1_ready", m1_ar_ready, 1);
    check("ar_second_m0_ready", m0_ar_ready, 0);
    tick;

    // Lone requester wins back-to-back with no bubble.
    m0_ar_valid = 0;
    #1;
    check("ar_solo1_id", s_ar_bits_id, 5'h19);
    check("ar_solo1_ready", m1_ar_ready, 1);
    tick;
    #1;
    check("ar_solo2_id", s_ar_bits_id, 5'h19);
    check("ar_solo2_ready", m1_ar_ready, 1);
    tick;
    m1_ar_valid = 0;

    // m0 handshake moves the pointer to m1, then a 5-cycle stall must keep m0 locked in.
    m0_ar_valid = 1; m0_ar_bits_id = 4'h1; m0_ar_bits_addr = 34'h3_0000_0300;
    #1;
    check("ar_pre_m0_ready", m0_ar_ready, 1);
    tick;
    s_ar_ready = 0; m0_ar_bits_id = 4'h4; m0_ar_bits_addr = 34'h0_dead_bee0;
    #1;
    check("stall0_id", s_ar_bits_id, 5'h04);
    check("stall0_addr", s_ar_bits_addr, 34'h0_dead_bee0);
    tick;
    m1_ar_valid = 1;
    for (int k = 1; k < 5; k++) begin
      #1;
      check($sformatf("stall%0d_id", k), s_ar_bits_id, 5'h04);
      check($sformatf("stall%0d_addr", k), s_ar_bits_addr, 34'h0_dead_bee0);
      check($sformatf("stall%0d_m1_ready", k), m1_ar_ready, 0);
      tick;
    end
    s_ar_ready = 1;
    #1;
    check("stall_release_m0_ready", m0_ar_ready, 1);
    check("stall_release_id", s_ar_bits_id, 5'h04);
    tick;
    m0_ar_valid = 0;
    #1;
    check("after_stall_m1_id", s_ar_bits_id, 5'h19);
    check("after_stall_m1_ready", m1_ar_ready, 1);
    tick;
    m1_ar_valid = 0; s_ar_ready = 0;

    // Interleaved read data and a write response, routed by id MSB.
    s_r_valid = 1; s_r_bits_id = 5'b1_0011; s_r_bits_data = 64'haaaa_0000_0000_0001; s_r_bits_last = 0;
    m1_r_ready = 1; m0_r_ready = 0;
    #1;
    check("r1_m1_valid", m1_r_valid, 1);
    check("r1_m0_valid", m0_r_valid, 0);
    check("r1_m1_id", m1_r_bits_id, 4'h3);
    check("r1_m1_data", m1_r_bits_data, 64'haaaa_0000_0000_0001);
    check("r1_m1_last", m1_r_bits_last, 0);
    check("r1_s_ready", s_r_ready, 1);
    tick;
    s_r_bits_id = 5'b0_0111; s_r_bits_data = 64'hbbbb_0000_0000_0002; s_r_bits_last = 1;
    #1;
    check("r2_m0_valid", m0_r_valid, 1);
    check("r2_m1_valid", m1_r_valid, 0);
    check("r2_m0_id", m0_r_bits_id, 4'h7);
    check("r2_m0_data", m0_r_bits_data, 64'hbbbb_0000_0000_0002);
    check("r2_m0_last", m0_r_bits_last, 1);
    check("r2_s_ready_backpressure", s_r_ready, 0);
    m0_r_ready = 1;
    #1;
    check("r2_s_ready", s_r_ready, 1);
    tick;
    s_r_bits_id = 5'b1_0011; s_r_bits_data = 64'haaaa_0000_0000_0003; s_r_bits_last = 1;
    #1;
    check("r3_m1_valid", m1_r_valid, 1);
    check("r3_m1_data", m1_r_bits_data, 64'haaaa_0000_0000_0003);
    check("r3_m1_last", m1_r_bits_last, 1);
    tick;
    s_r_valid = 0;
    s_b_valid = 1; s_b_bits_id = 5'b1_0101; s_b_bits_resp = 2'd2; m1_b_ready = 1;
    #1;
    check("b_m1_valid", m1_b_valid, 1);
    check("b_m0_valid", m0_b_valid, 0);
    check("b_m1_id", m1_b_bits_id, 4'h5);
    check("b_m1_resp", m1_b_bits_resp, 2'd2);
    check("b_s_ready", s_b_ready, 1);
    tick;
    s_b_valid = 0;

    // Two 4-beat bursts: m0 then m1; m1 held off its data the whole time.
    m0_aw_valid = 1; m0_aw_bits_id = 4'h3; m0_aw_bits_addr = 34'h0_0001_0000;
    m1_aw_valid = 1; m1_aw_bits_id = 4'h6; m1_aw_bits_addr = 34'h0_0002_0000;
    s_aw_ready = 1; s_w_ready = 1;
    m1_w_valid = 1; m1_w_bits_data = 64'hf1f1_f1f1_f1f1_f1f1;
    #1;
    check("w_idle_s_aw_valid", s_aw_valid, 0);
    check("w_idle_m0_aw_ready", m0_aw_ready, 0);
    tick;
    #1;
    check("aw0_valid", s_aw_valid, 1);
    check("aw0_id", s_aw_bits_id, 5'h03);
    check("aw0_addr", s_aw_bits_addr, 34'h0_0001_0000);
    check("aw0_m0_ready", m0_aw_ready, 1);
    check("aw0_m1_ready", m1_aw_ready, 0);
    check("aw0_no_w_ready", m0_w_ready, 0);
    check("aw0_no_s_w_valid", s_w_valid, 0);
    tick;
    m0_aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      m0_w_valid = 1; m0_w_bits_data = 64'h1000 + 64'(i); m0_w_bits_last = (i == 3);
      #1;
      check($sformatf("m0_beat%0d_valid", i), s_w_valid, 1);
      check($sformatf("m0_beat%0d_data", i), s_w_bits_data, 64'h1000 + 64'(i));
      check($sformatf("m0_beat%0d_last", i), s_w_bits_last, (i == 3) ? 1 : 0);
      check($sformatf("m0_beat%0d_m0_ready", i), m0_w_ready, 1);
      check($sformatf("m0_beat%0d_m1_ready", i), m1_w_ready, 0);
      check($sformatf("m0_beat%0d_m1_aw_ready", i), m1_aw_ready, 0);
      tick;
    end
    m0_w_bits_last = 0; m0_w_bits_data = 64'hdead;
    #1;
    check("m0_after_burst_s_w_valid", s_w_valid, 0);
    check("m0_after_burst_w_ready", m0_w_ready, 0);
    check("m0_after_burst_s_aw_valid", s_aw_valid, 0);
    m0_w_valid = 0;
    tick;
    #1;
    check("aw1_valid", s_aw_valid, 1);
    check("aw1_id", s_aw_bits_id, 5'h16);
    check("aw1_m1_ready", m1_aw_ready, 1);
    check("aw1_m1_w_ready", m1_w_ready, 0);
    tick;
    m1_aw_valid = 0; m0_w_valid = 1;
    for (int i = 0; i < 4; i++) begin
      m1_w_bits_data = 64'h2000 + 64'(i); m1_w_bits_last = (i == 3);
      #1;
      check($sformatf("m1_beat%0d_data", i), s_w_bits_data, 64'h2000 + 64'(i));
      check($sformatf("m1_beat%0d_last", i), s_w_bits_last, (i == 3) ? 1 : 0);
      check($sformatf("m1_beat%0d_m1_ready", i), m1_w_ready, 1);
      check($sformatf("m1_beat%0d_m0_ready", i), m0_w_ready, 0);
      tick;
    end
    m1_w_valid = 0; m1_w_bits_last = 0; m0_w_valid = 0;

    // AW withdrawn in W_ADDR holds the state; then reset lands mid-burst.
    m0_aw_valid = 1; m0_aw_bits_id = 4'h5;
    tick;
    m0_aw_valid = 0;
    #1;
    check("withdraw_s_aw_valid", s_aw_valid, 0);
    tick;
    m0_aw_valid = 1;
    #1;
    check("reraise_s_aw_valid", s_aw_valid, 1);
    check("reraise_id", s_aw_bits_id, 5'h05);
    check("reraise_m0_ready", m0_aw_ready, 1);
    tick;
    m0_aw_valid = 0;
    m0_w_valid = 1; m0_w_bits_data = 64'h3000; m0_w_bits_last = 0;
    m0_ar_valid = 1; s_ar_ready = 1; m0_ar_bits_id = 4'h4;
    #1;
    check("rb_beat0_data", s_w_bits_data, 64'h3000);
    check("rb_ar_m0_ready", m0_ar_ready, 1);
    tick;
    m0_ar_valid = 0; s_ar_ready = 0;
    m0_w_bits_data = 64'h3001;
    #1;
    check("rb_beat1_valid", s_w_valid, 1);
    tick;
    reset = 1'b0; m0_w_bits_data = 64'h3002;
    #1;
    check("rb_in_reset_s_w_valid", s_w_valid, 0);
    check("rb_in_reset_m0_w_ready", m0_w_ready, 0);
    tick;
    reset = 1'b1;
    #1;
    check("rb_after_s_w_valid", s_w_valid, 0);
    check("rb_after_m0_w_ready", m0_w_ready, 0);
    m0_w_valid = 0;
    m0_aw_valid = 1; m1_aw_valid = 1;
    m0_ar_valid = 1; m1_ar_valid = 1;
    #1;
    check("rb_ar_ptr_zero", s_ar_bits_id, 5'h04);
    tick;
    #1;
    check("rb_aw_ptr_zero", s_aw_bits_id, 5'h05);
    check("rb_aw_valid", s_aw_valid, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_axi4_arbiter.md
MEM_AXI4_ARBITER -- requirements
Module: mem_axi4_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 34, byte address width on all AR/AW channels.
REQ-002 Parameter DATA_BITS, default 64, R/W data width; strobe width is DATA_BITS/8.
REQ-003 Parameter ID_BITS, default 4, requester-side ID width; the slave-side ID width is ID_BITS+1.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low: 0 = reset asserted, sampled on the rising edge of clock.
REQ-006 m0_*/m1_* ar channel: valid in 1, ready out 1, bits_addr in ADDR_BITS, bits_id in ID_BITS, bits_size in 3, bits_len in 8.
REQ-007 m0_*/m1_* aw channel: the same fields and directions as ar.
REQ-008 m0_*/m1_* w channel: valid in 1, ready out 1, bits_strb in DATA_BITS/8, bits_data in DATA_BITS, bits_last in 1.
REQ-009 m0_*/m1_* r channel: valid out 1, ready in 1, bits_resp out 2, bits_id out ID_BITS, bits_data out DATA_BITS, bits_last out 1.
REQ-010 m0_*/m1_* b channel: valid out 1, ready in 1, bits_resp out 2, bits_id out ID_BITS.
REQ-011 s_* channels: the mirror of a single requester port (directions reversed), with ar/aw/r/b bits_id of width ID_BITS+1.

Function
REQ-012 s_ar_bits_id and s_aw_bits_id SHALL be {winner index, requester id}; the index occupies the MSB.
REQ-013 R and B routing SHALL use the MSB of s_r_bits_id/s_b_bits_id: 0 selects m0, 1 selects m1.
- Routed bits_id = low ID_BITS bits.
- The non-selected requester's valid = 0.
- s_*_ready = selected requester's ready, combinationally; 0 added latency.
REQ-014 AR arbitration SHALL be round-robin with a 1-bit priority pointer.
- When both requesters are valid, the winner is the one named by the pointer.
- After each accepted s_ar handshake, the pointer becomes the loser's index.
REQ-015 Once s_ar_valid is high with s_ar_ready low, the grant and all s_ar bits SHALL hold stable until the handshake completes (ar_lock register).
REQ-016 Only the granted requester SHALL see ar_ready = s_ar_ready; the other requester sees ar_ready = 0.
REQ-017 The write FSM SHALL have states W_IDLE, W_ADDR and W_DATA.
- W_IDLE: on any aw_valid, select by round-robin (separate aw pointer, same rule as REQ-014) and go to W_ADDR.
- W_ADDR: drive s_aw from the latched winner; on handshake go to W_DATA and flip the aw pointer to the loser.
- W_DATA: route only the winner's w to s_w; on a handshake with w_last = 1 go to W_IDLE.
REQ-018 The FSM SHALL give no w_ready to any requester outside W_DATA, and SHALL give aw_ready only in W_ADDR to the winner.
REQ-019 The arbiter SHALL impose no limit on outstanding reads or writes; ordering is the slave's responsibility.
REQ-020 R and B routing SHALL be independent of the AR/AW arbitration state; responses may arrive in any interleaving.
REQ-021 When a requester withdraws aw_valid in W_ADDR (a protocol violation), the FSM SHALL hold W_ADDR.
REQ-022 A single requester SHALL win every cycle regardless of pointer value; no idle bubble is inserted between its back-to-back grants.

Reset
REQ-023 While reset = 0, all registers SHALL take these values:
- ar pointer = 0, aw pointer = 0, ar_lock = 0;
- FSM = W_IDLE;
- latched write winner = 0.
REQ-024 During reset, all ready and valid outputs SHALL be 0; data outputs are don't-care.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no further w beats forwarded; recovery is the system's responsibility.

Structure
REQ-026 A shared package SHALL hold the FSM state enum and the REQ_IDX_BITS = 1 constant.
REQ-027 There SHALL be one sub-module, rr_arb2: a 2-way round-robin picker with lock input, instanced for AR and for AW.

Verification
REQ-028 m0 and m1 assert ar_valid in the same cycle, pointer = 0 -> s_ar carries m0 with s id = {0,id}, then m1 the next accepted cycle with s id = {1,id}.
REQ-029 s_ar_ready held low for 5 cycles while m1 raises ar_valid mid-stall -> s_ar bits unchanged for all 5 cycles and m0 is granted first.
REQ-030 Two 4-beat bursts (m0 then m1), len = 3 -> exactly 4 w beats from m0 with last on beat 4, then the m1 AW; m1 w_ready stays 0 throughout m0's W_DATA.
REQ-031 s_r returns id = 5'b1_0011 then 5'b0_0111, interleaved -> m1 sees id 4'h3, m0 sees id 4'h7, each with the correct data and last.
REQ-032 Reset driven to 0 in W_DATA after 2 of 4 beats, then released -> FSM = W_IDLE, pointers = 0, no stray s_w_valid.
